exhaustive_sweep_checker: RTL and testbench
===========================================

// Module: exhaustive_sweep_checker
// PURPOSE
//  Self-running equivalence checker for two combinational/pipelined detectors.
//  Drives every one of the 2^WIDTH input vectors onto a shared bus M.
//  Samples both detector outputs and counts disagreements.
//  Records the first mismatching vector and pulses done at the end.
//  Successor to the fixed 9-bit sweep: width, DUT latency and early abort are now configurable.
// PARAMETERS
//  WIDTH    9  vector width; the sweep covers 0 .. 2^WIDTH-1
//  LATENCY  0  DUT register stages between M and out1/out2 (0 = combinational)
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        asynchronous active-low reset
//  start           in   1        begin a sweep; sampled only in IDLE
//  out1            in   1        output of detector 1
//  out2            in   1        output of detector 2
//  M               out  WIDTH    stimulus vector to both detectors
//  busy            out  1        high in SWEEP and DRAIN
//  done            out  1        one-cycle pulse when results are final
//  mismatch_cnt    out  WIDTH+1  count of sampled vectors with out1 != out2
//  first_mismatch  out  WIDTH    first vector where out1 != out2
//  first_valid     out  1        first_mismatch holds a valid value
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, M=0, busy=0, done=0, mismatch_cnt=0,
//    first_mismatch=0, first_valid=0, tag pipe cleared. A sweep in flight is discarded.
//  - FSM states: IDLE -> SWEEP -> DRAIN -> IDLE.
//  - IDLE: on an edge with start=1, the block does the following:
//    - clears the counters and first_valid;
//    - sets M=0 and busy=1;
//    - moves to SWEEP.
//  - SWEEP: M increments by 1 each cycle.
//    - At the edge where M==2^WIDTH-1, M holds and the state moves to DRAIN.
//    - No wrap to 0.
//  - Tag pipe: a valid+vector shift register of depth LATENCY+1 tracks each issued M.
//    - out1/out2 are sampled at the edge where the tag for vector v exits the pipe.
//    - That edge is edge(issue of v) + LATENCY + 1.
//  - Sampling rules:
//    - If out1 != out2, mismatch_cnt increments.
//    - If out1 != out2 and first_valid=0, first_mismatch=v and first_valid=1.
//    - mismatch_cnt max is 2^WIDTH, which fits in WIDTH+1 bits; there is no saturation logic.
//  - DRAIN: lasts until the last tag (2^WIDTH-1) is sampled.
//    - On that edge: state=IDLE, busy=0, done=1 for exactly one cycle.
//  - Timing: start sampled at edge S -> done high in the cycle after edge S+2^WIDTH+LATENCY.
//  - Result hold: counts, first_* and M hold in IDLE until the next accepted start.
//  - start while busy: ignored, with no restart and no effect on counts.
//  - start and done coincide: start is sampled in IDLE, so a new sweep begins.
//    - done is still a single pulse.
//  - Sampling during IDLE (no valid tag): out1/out2 are ignored.
// CONFIGURATION
//  STOP_ON_MISMATCH_EN
//    - Defined: the first sampled mismatch aborts the sweep.
//      - On that edge: first_mismatch/first_valid are captured, mismatch_cnt=1,
//        state=IDLE, busy=0, done pulses.
//      - Tags still in flight are discarded and M holds its current value.
//    - Undefined: the full sweep always runs and all mismatches are counted.
// TESTING
//  1 WIDTH=9 LAT=0, out1=out2=^M, start at S
//    -> done one cycle after edge S+512; mismatch_cnt=0; first_valid=0; M=511.
//  2 WIDTH=9 LAT=0, out2 inverted only at M=9'h0A5
//    -> mismatch_cnt=1; first_mismatch=9'h0A5; first_valid=1.
//  3 WIDTH=9 LAT=2, registered models differing at 300 and 301
//    -> mismatch_cnt=2; first_mismatch=300; done after edge S+514.
//  4 Assert rst_n=0 when M=200 mid-sweep
//    -> all outputs 0 immediately; a new start gives a full clean result.
//  5 start pulsed at M=50 during SWEEP
//    -> ignored; done timing and counts identical to scenario 1.
//  6 STOP_ON_MISMATCH_EN, WIDTH=6 LAT=1, mismatches at 17 and 40
//    -> done after edge S+19; mismatch_cnt=1; first_mismatch=17.

Source files
------------

// File: rtl/exhaustive_sweep_checker_if.sv
// Bus between the sweep checker and its two detectors / controller.
// master: the checker (drives M and results); slave: the environment
// (drives start and the two detector outputs).
interface exhaustive_sweep_checker_if #(
  parameter int WIDTH = 9
);
  logic             start;
  logic             out1;
  logic             out2;
  logic [WIDTH-1:0] M;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   mismatch_cnt;
  logic [WIDTH-1:0] first_mismatch;
  logic             first_valid;

  modport master (
    input  start, out1, out2,
    output M, busy, done, mismatch_cnt, first_mismatch, first_valid
  );

  modport slave (
    output start, out1, out2,
    input  M, busy, done, mismatch_cnt, first_mismatch, first_valid
  );
endinterface

// File: rtl/exhaustive_sweep_checker.sv
// Exhaustive sweep equivalence checker: drives every WIDTH-bit vector onto M,
// compares the two detector outputs LATENCY+1 edges later via a tag pipe,
// counts disagreements and records the first failing vector.
// Optional build macro: STOP_ON_MISMATCH_EN (abort the sweep on the first
// sampled mismatch). Default build runs the full sweep.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | results held, waiting for start
// ST_SWEEP | issuing vectors 0 .. 2^WIDTH-1 on M, one per cycle
// ST_DRAIN | M parked at the last vector, waiting for the last tag to exit
module exhaustive_sweep_checker #(
  parameter int WIDTH   = 9,
  parameter int LATENCY = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  exhaustive_sweep_checker_if.master bus
);

  localparam logic [WIDTH-1:0] M_LAST = '1;
`ifdef STOP_ON_MISMATCH_EN
  localparam bit STOP_ON_MISMATCH = 1'b1;
`else
  localparam bit STOP_ON_MISMATCH = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] w_m_nxt;
  logic             w_issue;
  logic             w_clear;
  logic             w_finish;
  logic             w_abort;

  // Tag pipe: stage 0 is loaded on the edge a vector appears on M, so the
  // last stage presents that vector exactly when its detector result is due.
  logic [LATENCY:0] r_tag_v;
  logic [WIDTH-1:0] r_tag_d [LATENCY+1];

  logic [WIDTH:0]   r_cnt;
  logic [WIDTH-1:0] r_first;
  logic             r_first_valid;
  logic             r_done;

  logic             w_sample;
  logic             w_diff;
  logic             w_last;
  logic [WIDTH-1:0] w_tag_out;

  assign w_tag_out = r_tag_d[LATENCY];
  assign w_sample  = r_tag_v[LATENCY] && (r_state != ST_IDLE);
  assign w_diff    = w_sample && (bus.out1 != bus.out2);
  assign w_last    = w_sample && (w_tag_out == M_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and control decode. With LATENCY=0 the last tag exits on the
  // same edge SWEEP reaches M_LAST, so the finish test outranks entering DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_issue     = 1'b0;
    w_clear     = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SWEEP;
          w_m_nxt     = '0;
          w_issue     = 1'b1;
          w_clear     = 1'b1;
        end
      end
      ST_SWEEP, ST_DRAIN: begin
        if (STOP_ON_MISMATCH && w_diff) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
          w_abort     = 1'b1;
        end else if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end else if (r_state == ST_SWEEP) begin
          if (r_m == M_LAST) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_m_nxt = r_m + 1'b1;
            w_issue = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stimulus vector; holds whenever nothing new is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_m <= '0;
    else if (w_issue) r_m <= w_m_nxt;
  end

  // Tag pipe shift; an abort throws away everything still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      for (int k = 0; k <= LATENCY; k++) r_tag_d[k] <= '0;
    end else if (w_abort) begin
      r_tag_v <= '0;
    end else begin
      r_tag_v[0] <= w_issue;
      r_tag_d[0] <= w_m_nxt;
      for (int k = 1; k <= LATENCY; k++) begin
        r_tag_v[k] <= r_tag_v[k-1];
        r_tag_d[k] <= r_tag_d[k-1];
      end
    end
  end

  // Mismatch count and first-failure capture; cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_first       <= '0;
      r_first_valid <= 1'b0;
    end else if (w_clear) begin
      r_cnt         <= '0;
      r_first       <= '0;
      r_first_valid <= 1'b0;
    end else if (w_diff) begin
      r_cnt <= r_cnt + 1'b1;
      if (!r_first_valid) begin
        r_first       <= w_tag_out;
        r_first_valid <= 1'b1;
      end
    end
  end

  // Single-cycle done pulse following the finishing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_finish;
  end

  assign bus.M              = r_m;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.done           = r_done;
  assign bus.mismatch_cnt   = r_cnt;
  assign bus.first_mismatch = r_first;
  assign bus.first_valid    = r_first_valid;

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// Bench for exhaustive_sweep_checker: three instances (9/0, 9/2, 6/1) driven
// by small detector models; expected results are queued at start and
// compared when done pulses.
module tb_exhaustive_sweep_checker;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    int cnt;
    int fv;
    int fm;
    int m;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  exhaustive_sweep_checker_if #(.WIDTH(9)) ifa ();
  exhaustive_sweep_checker_if #(.WIDTH(9)) ifb ();
  exhaustive_sweep_checker_if #(.WIDTH(6)) ifc ();

  exhaustive_sweep_checker #(.WIDTH(9), .LATENCY(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  exhaustive_sweep_checker #(.WIDTH(9), .LATENCY(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  exhaustive_sweep_checker #(.WIDTH(6), .LATENCY(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Detector models: A combinational parity with one injectable fault,
  // B two register stages faulty at 300/301, C one stage faulty at 17/40.
  int a_inj = -1;
  assign ifa.out1 = ^ifa.M;
  assign ifa.out2 = (^ifa.M) ^ (int'(ifa.M) == a_inj);

  logic [8:0] b_r1 = '0, b_r2 = '0;
  logic [5:0] c_r1 = '0;
  always @(posedge clk) begin
    b_r1 <= ifb.M;
    b_r2 <= b_r1;
    c_r1 <= ifc.M;
  end
  assign ifb.out1 = ^b_r2;
  assign ifb.out2 = (^b_r2) ^ ((b_r2 == 9'd300) || (b_r2 == 9'd301));
  assign ifc.out1 = ^c_r1;
  assign ifc.out2 = (^c_r1) ^ ((c_r1 == 6'd17) || (c_r1 == 6'd40));

  task automatic chk(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic score(string tag, int have, exp_t e, int d_cnt, int d_fv,
                       int d_fm, int d_m, int d_busy);
    chk({tag, "_done_expected"}, have, 1);
    if (have != 0) begin
      chk({tag, "_done_cycle"}, cyc, e.cyc);
      chk({tag, "_mismatch_cnt"}, d_cnt, e.cnt);
      chk({tag, "_first_valid"}, d_fv, e.fv);
      if (e.fv != 0) chk({tag, "_first_mismatch"}, d_fm, e.fm);
      chk({tag, "_M_final"}, d_m, e.m);
      chk({tag, "_busy_at_done"}, d_busy, 0);
    end
  endtask

  // Scoreboard monitors: pop and compare on every done pulse, and check the
  // pulse is a single cycle wide.
  int   ha, hb, hc;
  exp_t ea, eb, ec;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pa = 1'b0; pb = 1'b0; pc = 1'b0;
    end else begin
      if (pa) chk("a_done_pulse", int'(ifa.done), 0);
      if (pb) chk("b_done_pulse", int'(ifb.done), 0);
      if (pc) chk("c_done_pulse", int'(ifc.done), 0);
      if (ifa.done) begin
        ha = int'(qa.size() != 0);
        if (ha != 0) ea = qa.pop_front();
        score("a", ha, ea, int'(ifa.mismatch_cnt), int'(ifa.first_valid),
              int'(ifa.first_mismatch), int'(ifa.M), int'(ifa.busy));
      end
      if (ifb.done) begin
        hb = int'(qb.size() != 0);
        if (hb != 0) eb = qb.pop_front();
        score("b", hb, eb, int'(ifb.mismatch_cnt), int'(ifb.first_valid),
              int'(ifb.first_mismatch), int'(ifb.M), int'(ifb.busy));
      end
      if (ifc.done) begin
        hc = int'(qc.size() != 0);
        if (hc != 0) ec = qc.pop_front();
        score("c", hc, ec, int'(ifc.mismatch_cnt), int'(ifc.first_valid),
              int'(ifc.first_mismatch), int'(ifc.M), int'(ifc.busy));
      end
      pa = ifa.done; pb = ifb.done; pc = ifc.done;
    end
  end

  function automatic int qsize(int sel);
    case (sel)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  // e.cyc carries the offset from the start edge; it becomes absolute here.
  task automatic kick(int sel, exp_t e);
    @(negedge clk);
    e.cyc = cyc + 1 + e.cyc;
    case (sel)
      0:       begin qa.push_back(e); ifa.start = 1'b1; end
      1:       begin qb.push_back(e); ifb.start = 1'b1; end
      default: begin qc.push_back(e); ifc.start = 1'b1; end
    endcase
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
  endtask

  task automatic wait_drain(string tag, int sel, int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_timeout"}, qsize(sel), 0);
  endtask

  task automatic wait_ma(string tag, int value, int budget);
    int n = 0;
    while (int'(ifa.M) != value && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach_M"}, int'(ifa.M), value);
  endtask

  initial begin
    exp_t e;
    int   n;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_M", int'(ifa.M), 0);
    chk("rst_a_busy", int'(ifa.busy), 0);
    chk("rst_a_done", int'(ifa.done), 0);
    chk("rst_a_cnt", int'(ifa.mismatch_cnt), 0);
    chk("rst_a_fm", int'(ifa.first_mismatch), 0);
    chk("rst_a_fv", int'(ifa.first_valid), 0);
    chk("rst_b_busy", int'(ifb.busy), 0);
    chk("rst_c_M", int'(ifc.M), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep, combinational detectors.
    a_inj = -1;
    e = '{512, 0, 0, 0, 511};
    kick(0, e);
    chk("a_busy_sweep", int'(ifa.busy), 1);
    wait_drain("s1", 0, 700);

    // Single fault at 0x0A5.
    a_inj = 'h0A5;
    e = '{512, 1, 1, 'h0A5, 511};
    kick(0, e);
    wait_drain("s2", 0, 700);

    // start pulsed mid-sweep is ignored.
    a_inj = -1;
    e = '{512, 0, 0, 0, 511};
    kick(0, e);
    wait_ma("s5", 50, 700);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_drain("s5", 0, 700);

    // Async reset mid-sweep discards the sweep; a clean rerun follows.
    a_inj = 10;
    e = '{512, 1, 1, 10, 511};
    kick(0, e);
    wait_ma("s4", 200, 700);
    chk("s4_cnt_before_rst", int'(ifa.mismatch_cnt), 1);
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete();
    chk("s4_rst_M", int'(ifa.M), 0);
    chk("s4_rst_busy", int'(ifa.busy), 0);
    chk("s4_rst_cnt", int'(ifa.mismatch_cnt), 0);
    chk("s4_rst_fv", int'(ifa.first_valid), 0);
    chk("s4_rst_fm", int'(ifa.first_mismatch), 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_inj = -1;
    e = '{512, 0, 0, 0, 511};
    kick(0, e);
    wait_drain("s4_rerun", 0, 700);

    // start on the done cycle launches a new sweep immediately.
    a_inj = 'h1FF;
    e = '{512, 1, 1, 'h1FF, 511};
    kick(0, e);
    n = 0;
    while (!ifa.done && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", int'(ifa.done), 1);
    a_inj = 3;
    e = '{512, 1, 1, 3, 511};
    e.cyc = cyc + 1 + e.cyc;
    qa.push_back(e);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    chk("b2b_busy", int'(ifa.busy), 1);
    wait_drain("b2b", 0, 700);

    // Registered detectors, two stages, faults at 300 and 301.
    e = '{514, 2, 1, 300, 511};
    kick(1, e);
    wait_drain("s3", 1, 700);

    // Width 6, one stage, faults at 17 and 40.
`ifdef STOP_ON_MISMATCH_EN
    e = '{19, 1, 1, 17, 18};
`else
    e = '{65, 2, 1, 17, 63};
`endif
    kick(2, e);
    wait_drain("s6", 2, 200);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
